// File: rtl/fwd_hazard_tracker.sv
// ---------------------------------------------------------------------------
// fwd_hazard_tracker
//   Forwarding and load-use hazard unit for the pipelined core. It keeps its
//   own shift register of in-flight instruction tags (E stage plus
//   NUM_FWD_STAGES producer stages). From that state it drives the E-stage
//   operand forward selects, the F/D stall and the D/E bubble.
//
// Ports
//   clk          : clock, rising edge
//   reset        : asynchronous reset, active-low
//   valid_d      : D-stage slot holds a real instruction
//   src_d        : D-stage source registers, operand i at [i*AW +: AW]
//   dest_d       : D-stage destination register
//   regwrite_d   : D-stage instruction writes dest_d
//   isload_d     : D-stage instruction is a load
//   flush_e      : squash the D instruction entering E
//   fwd_sel_e    : per-operand select, 0 = regfile value, k = stage k result
//   stall_fd     : hold the PC and the F/D register
//   bubble_e     : load a NOP into the D/E register
//   stall_cycles : saturating count of cycles with stall_fd = 1
// ---------------------------------------------------------------------------
module fwd_hazard_tracker #(
  parameter int NUM_SRC        = 2,
  parameter int AW             = 5,
  parameter int NUM_FWD_STAGES = 2,
  parameter int LOAD_LAT       = 2,
  parameter int SEL_W          = $clog2(NUM_FWD_STAGES + 1),
  parameter int CNT_W          = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_d,
  input  logic [NUM_SRC*AW-1:0]    src_d,
  input  logic [AW-1:0]            dest_d,
  input  logic                     regwrite_d,
  input  logic                     isload_d,
  input  logic                     flush_e,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel_e,
  output logic                     stall_fd,
  output logic                     bubble_e,
  output logic [CNT_W-1:0]         stall_cycles
);

  localparam int NS = NUM_FWD_STAGES;
  // A load's isload flag is only inspected while it can still cause a stall
  // (entries 0..LOAD_LAT-2), so it is only carried that far.
  localparam int LD_TOP = (LOAD_LAT >= 2) ? LOAD_LAT - 2 : 0;

  // Entry 0 is the E stage, entry k is producer stage k.
  logic [NS:0]     valid_q;
  logic [NS:0]     rw_q;
  logic [AW-1:0]   dest_q [NS+1];
  logic [LD_TOP:0] ld_q;
  logic [AW-1:0]   esrc_q [NUM_SRC];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             e_valid_d;

  logic [NUM_SRC-1:0] hz_vec;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    logic [AW-1:0]    d_src;
    logic             hz;
    logic [SEL_W-1:0] sel;

    assign d_src = src_d[gi*AW +: AW];

    always_comb begin
      // Load-use: a load not yet at its data stage blocks a D consumer.
      hz = 1'b0;
      for (int p = 0; p < LOAD_LAT - 1; p++) begin
        if (valid_q[p] && ld_q[p] && rw_q[p] &&
            (dest_q[p] == d_src) && (d_src != '0)) begin
          hz = 1'b1;
        end
      end
      // Scan oldest to youngest so the youngest matching producer wins.
      sel = '0;
      for (int k = NS; k >= 1; k--) begin
        if (valid_q[k] && rw_q[k] &&
            (dest_q[k] == esrc_q[gi]) && (esrc_q[gi] != '0)) begin
          sel = SEL_W'(k);
        end
      end
      if (!valid_q[0]) begin
        sel = '0;
      end
    end

    assign hz_vec[gi]                     = hz;
    assign fwd_sel_e[gi*SEL_W +: SEL_W]   = sel;
  end

  // A flushed instruction never needs to wait, so flush masks the stall.
  assign stall_fd  = reset & valid_d & ~flush_e & (|hz_vec);
  assign bubble_e  = reset & (stall_fd | flush_e);
  assign e_valid_d = valid_d & ~stall_fd & ~flush_e;
  assign cnt_d     = (stall_fd && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
  assign stall_cycles = cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      rw_q    <= '0;
      ld_q    <= '0;
      for (int k = 0; k <= NS; k++) dest_q[k] <= '0;
      for (int i = 0; i < NUM_SRC; i++) esrc_q[i] <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q[0] <= e_valid_d;
      rw_q[0]    <= regwrite_d;
      dest_q[0]  <= dest_d;
      ld_q[0]    <= isload_d;
      for (int i = 0; i < NUM_SRC; i++) esrc_q[i] <= src_d[i*AW +: AW];
      // Downstream of E the pipeline never stalls: shift every clock.
      for (int k = 1; k <= NS; k++) begin
        valid_q[k] <= valid_q[k-1];
        rw_q[k]    <= rw_q[k-1];
        dest_q[k]  <= dest_q[k-1];
      end
      for (int k = 1; k <= LD_TOP; k++) ld_q[k] <= ld_q[k-1];
      cnt_q <= cnt_d;
    end
  end

endmodule
